// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared definitions for the RV32I multi-cycle core control.
//               Holds the major opcodes, the control FSM state encoding, the
//               ALU operation selector and the branch funct3 codes.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Major opcodes, ir[6:0]. These are also used by the immediate generator.
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Control FSM states. FETCH is 0 so that the reset state reads as zero on
    // the debug port.
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC     = 4'd2,
        ST_MEM_ADDR = 4'd3,
        ST_MEM_RD   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_WB_ALU   = 4'd6,
        ST_WB_MEM   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_FAULT    = 4'd9
    } state_t;

    // ALU operation selector
    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_FUNCT = 2'b01,
        ALU_CMP   = 2'b10
    } alu_op_t;

    // Branch funct3 codes, ir[14:12]. 010 and 011 are not defined.
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage
`default_nettype wire

// File: rtl/riscv_mc_ctrl_branch_cond.sv
`default_nettype none
// ============================================================================
// Module      : branch_cond
// Description : Combinational branch resolution. It maps the branch funct3 and
//               the ALU compare flags to a taken flag, and it flags the
//               undefined funct3 encodings as illegal.
// Ports       : funct3  in  3  branch funct3 (ir[14:12])
//               cmp_eq  in  1  rs1 == rs2
//               cmp_lt  in  1  rs1 <  rs2, signed
//               cmp_ltu in  1  rs1 <  rs2, unsigned
//               taken   out 1  branch condition holds
//               illegal out 1  funct3 is not a defined branch
// Revision    : 1.0 - initial release
// ============================================================================
module branch_cond
    import riscv_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       cmp_eq,
    input  logic       cmp_lt,
    input  logic       cmp_ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = cmp_eq;
            F3_BNE:  taken = ~cmp_eq;
            F3_BLT:  taken = cmp_lt;
            F3_BGE:  taken = ~cmp_lt;
            F3_BLTU: taken = cmp_ltu;
            F3_BGEU: taken = ~cmp_ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/riscv_mc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : riscv_mc_ctrl
// Description : Multi-cycle control FSM for the RV32I datapath. It sequences
//               fetch, decode, execute, memory and write-back for R-type,
//               I-type ALU, load, store and branch instructions. It shares one
//               memory port between fetch and data access, counts retired
//               instructions, and traps illegal opcodes and memory timeouts.
// Ports       : clk, rst_n            clock, async active-low reset
//               ir                    instruction register (valid from DECODE)
//               cmp_eq/lt/ltu         ALU compare flags
//               mem_ready             memory handshake
//               mem_req/we/addr_sel   memory request controls
//               ir_we, pc_we, pc_src  IR / PC update controls
//               rf_we, wb_sel         register write-back controls
//               alu_src_b, alu_op     ALU operand / operation select
//               fault                 sticky fault flag
//               instret               retired-instruction counter
//               state_o               current FSM state (debug)
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_mc_ctrl
    import riscv_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ir,
    input  logic        cmp_eq,
    input  logic        cmp_lt,
    input  logic        cmp_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        fault,
    output logic [31:0] instret,
    output logic [3:0]  state_o
);

    // Last wait-counter value tolerated before a stalled request faults.
    localparam logic [7:0] c_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_wait_cnt;
    logic [31:0] r_instret;
    logic        r_active;
    logic        w_retire;
    logic        w_timeout;
    logic        w_req_state;
    logic        w_is_imm;
    logic        w_taken;
    logic        w_br_illegal;
    alu_op_t     w_alu_op;
    logic [6:0]  w_opcode;
    logic        w_unused;

    assign w_opcode = ir[6:0];
    assign w_is_imm = (w_opcode == OP_IMM);
    // Only the opcode and funct3 fields steer control.
    assign w_unused = ^{ir[31:15], ir[11:7]};

    branch_cond u_branch_cond (
        .funct3  (ir[14:12]),
        .cmp_eq  (cmp_eq),
        .cmp_lt  (cmp_lt),
        .cmp_ltu (cmp_ltu),
        .taken   (w_taken),
        .illegal (w_br_illegal)
    );

    // r_active is low while reset is held and for the first edge after
    // release, so every output (mem_req included) is 0 under reset and the
    // first fetch request starts on the first clock edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
        end else begin
            r_active <= 1'b1;
        end
    end

    assign w_req_state = r_active &&
                         ((r_state == ST_FETCH) || (r_state == ST_MEM_RD) ||
                          (r_state == ST_MEM_WR));
    // mem_ready in the same cycle wins over the timeout.
    assign w_timeout   = w_req_state && !mem_ready && (r_wait_cnt == c_WAIT_LAST);

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_FETCH: begin
                if (r_active && mem_ready) begin
                    w_next_state = ST_DECODE;
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_DECODE: begin
                case (w_opcode)
                    OP_R, OP_IMM:       w_next_state = ST_EXEC;
                    OP_LOAD, OP_STORE:  w_next_state = ST_MEM_ADDR;
                    OP_BRANCH:          w_next_state = ST_BRANCH;
                    default:            w_next_state = ST_FAULT;
                endcase
            end
            ST_EXEC:     w_next_state = ST_WB_ALU;
            ST_WB_ALU:   w_next_state = ST_FETCH;
            ST_MEM_ADDR: w_next_state = (w_opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    w_next_state = ST_WB_MEM;
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_WB_MEM:   w_next_state = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    w_next_state = ST_FETCH;
                end else if (w_timeout) begin
                    w_next_state = ST_FAULT;
                end
            end
            ST_BRANCH:   w_next_state = w_br_illegal ? ST_FAULT : ST_FETCH;
            ST_FAULT:    w_next_state = ST_FAULT;
            default:     w_next_state = ST_FAULT;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        rf_we        = 1'b0;
        wb_sel       = 1'b0;
        alu_src_b    = 1'b0;
        w_alu_op     = ALU_ADD;
        fault        = 1'b0;
        w_retire     = 1'b0;
        if (r_active) begin
            case (r_state)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    ir_we   = mem_ready;
                end
                ST_DECODE: begin
                    alu_src_b = w_is_imm;
                end
                ST_EXEC: begin
                    w_alu_op  = ALU_FUNCT;
                    alu_src_b = w_is_imm;
                end
                ST_WB_ALU: begin
                    rf_we    = 1'b1;
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                end
                ST_MEM_ADDR: begin
                    alu_src_b = 1'b1;
                end
                ST_MEM_RD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                ST_WB_MEM: begin
                    rf_we    = 1'b1;
                    wb_sel   = 1'b1;
                    pc_we    = 1'b1;
                    w_retire = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                    pc_we        = mem_ready;
                    w_retire     = mem_ready;
                end
                ST_BRANCH: begin
                    w_alu_op = ALU_CMP;
                    pc_we    = ~w_br_illegal;
                    pc_src   = w_taken & ~w_br_illegal;
                    w_retire = ~w_br_illegal;
                end
                ST_FAULT: begin
                    fault = 1'b1;
                end
                default: begin
                    fault = 1'b0;
                end
            endcase
        end
    end

    // Wait counter: counts stalled cycles of the current request and is zero
    // whenever the FSM enters a request state or the request completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (w_req_state && !mem_ready && (w_next_state == r_state)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end else begin
            r_wait_cnt <= 8'd0;
        end
    end

    // Retired-instruction counter, wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (w_retire) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    assign alu_op  = w_alu_op;
    assign instret = r_instret;
    assign state_o = r_state;

endmodule
`default_nettype wire
